// File: rtl/cache_ctrl.sv
// Request controller for a direct-mapped, write-through, no-write-allocate cache.
// Sequences RAM lookup, miss handling over a req/ack memory port, and line fill.
module cache_ctrl #(
   parameter int index       = 3,
   parameter int cachesize   = 8,
   parameter int memory_bits = 5,
   parameter int data_bits   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [memory_bits-1:0]       cpu_addr,
   input  logic [data_bits-1:0]         cpu_wdata,
   output logic [data_bits-1:0]         cpu_rdata,
   output logic                         cpu_ready,
   output logic                         cpu_busy,
   output logic                         read_signal,
   output logic                         write_signal,
   output logic [index-1:0]             ram_index,
   output logic [memory_bits-index-1:0] ram_tag,
   output logic [data_bits-1:0]         ram_wdata,
   input  logic                         valid_in,
   input  logic [memory_bits-index-1:0] tag_in,
   input  logic [data_bits-1:0]         line_in,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [memory_bits-1:0]       mem_addr,
   output logic [data_bits-1:0]         mem_wdata,
   input  logic [data_bits-1:0]         mem_rdata,
   input  logic                         mem_ack,
   output logic [7:0]                   hit_count,
   output logic [7:0]                   miss_count
);

   localparam int T = memory_bits - index;

   if (cachesize != (1 << index)) begin : g_bad_cfg
      $error("cache_ctrl: cachesize must equal 2**index");
   end

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM, FILL, RESP} state_t;

   state_t                   state_q, state_d;
   logic                     we_q, we_d;
   logic [memory_bits-1:0]   addr_q, addr_d;
   logic [data_bits-1:0]     wdata_q, wdata_d;
   logic [data_bits-1:0]     fetch_q, fetch_d;
   logic [data_bits-1:0]     rdata_q, rdata_d;
   logic                     whit_q, whit_d;
   logic                     mem_req_q, mem_req_d;
   logic                     mem_we_q, mem_we_d;
   logic [memory_bits-1:0]   mem_addr_q, mem_addr_d;
   logic [data_bits-1:0]     mem_wdata_q, mem_wdata_d;
   logic [7:0]               hit_cnt_q, hit_cnt_d;
   logic [7:0]               miss_cnt_q, miss_cnt_d;
   logic                     hit;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign hit = valid_in && (tag_in == addr_q[memory_bits-1:index]);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      fetch_d     = fetch_q;
      rdata_d     = rdata_q;
      whit_d      = whit_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (!we_q && hit) begin
               rdata_d   = line_in;
               hit_cnt_d = sat_inc(hit_cnt_q);
               state_d   = RESP;
            end else begin
               // Every write goes to memory; reads go only on a miss.
               mem_req_d  = 1'b1;
               mem_we_d   = we_q;
               mem_addr_d = addr_q;
               if (we_q) mem_wdata_d = wdata_q;
               whit_d = we_q && hit;
               if (we_q && hit) hit_cnt_d = sat_inc(hit_cnt_q);
               else             miss_cnt_d = sat_inc(miss_cnt_q);
               state_d = MEM;
            end
         end
         MEM: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (!we_q) begin
                  fetch_d = mem_rdata;
                  state_d = FILL;
               end else if (whit_q) begin
                  state_d = FILL;
               end else begin
                  state_d = RESP;
               end
            end
         end
         FILL: begin
            if (!we_q) rdata_d = fetch_q;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         fetch_q     <= '0;
         rdata_q     <= '0;
         whit_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         fetch_q     <= fetch_d;
         rdata_q     <= rdata_d;
         whit_q      <= whit_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Lookup strobe is combinational so the RAMs return data in LOOKUP.
   assign read_signal  = (state_q == IDLE) && cpu_req && !reset;
   assign write_signal = (state_q == FILL);
   assign ram_index    = addr_q[index-1:0];
   assign ram_tag      = addr_q[memory_bits-1:index];
   assign ram_wdata    = we_q ? wdata_q : fetch_q;
   assign cpu_ready    = (state_q == RESP);
   assign cpu_busy     = (state_q != IDLE);
   assign cpu_rdata    = rdata_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;

   logic [T-1:0] unused_tag_w;
   assign unused_tag_w = ram_tag;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scenario bench for cache_ctrl: cycle-driven transactions with a queue of
// expected cpu_rdata values popped on each cpu_ready.
module tb_cache_ctrl;

   logic       clk, reset, cpu_req, cpu_we;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata, cpu_rdata;
   logic       cpu_ready, cpu_busy, read_signal, write_signal;
   logic [2:0] ram_index;
   logic [1:0] ram_tag;
   logic [7:0] ram_wdata;
   logic       valid_in;
   logic [1:0] tag_in;
   logic [7:0] line_in;
   logic       mem_req, mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_ack;
   logic [7:0] hit_count, miss_count;

   cache_ctrl #(.index(3), .cachesize(8), .memory_bits(5), .data_bits(8)) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .read_signal(read_signal),
      .write_signal(write_signal), .ram_index(ram_index), .ram_tag(ram_tag),
      .ram_wdata(ram_wdata), .valid_in(valid_in), .tag_in(tag_in), .line_in(line_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ready_cyc;
      int         req_cyc;
      int         ws_count;
      int         mreq_rises;
      int         rs_busy;
      int         both;
      logic       rs0;
      logic       busy_after;
      logic [4:0] maddr;
      logic       mwe;
      logic [7:0] mwdata;
      logic [2:0] idx;
      logic [1:0] tag;
      logic [7:0] rwd;
   } res_t;

   int         n_checks;
   int         n_fails;
   logic [7:0] exp_q[$];
   logic [7:0] last_rdata;
   int         exp_hit, exp_miss;

   // One complete CPU transaction; memory acks k cycles after mem_req is first seen.
   task automatic txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                      input logic vin, input logic [1:0] tin, input logic [7:0] lin,
                      input int k, input logic [7:0] mdata, input logic extra, output res_t r);
      logic       prev_req, is_hit;
      int         ack_at;
      logic [7:0] exp_v;
      r = '{default: 0};
      r.ready_cyc = -1; r.req_cyc = -1; prev_req = 1'b0; ack_at = -1;
      is_hit = vin && (tin == addr[4:3]);
      if (!we) last_rdata = is_hit ? lin : mdata;
      exp_q.push_back(last_rdata);
      if (is_hit) exp_hit = (exp_hit < 255) ? exp_hit + 1 : 255;
      else        exp_miss = (exp_miss < 255) ? exp_miss + 1 : 255;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      #1 r.rs0 = read_signal;
      for (int cyc = 1; cyc <= 40 && r.ready_cyc < 0; cyc++) begin
         @(negedge clk);
         cpu_req = extra && (cyc == 3);
         mem_ack = 1'b0;
         valid_in = (cyc == 1) ? vin : 1'b0;
         tag_in   = (cyc == 1) ? tin : 2'b00;
         line_in  = (cyc == 1) ? lin : 8'h00;
         #1;
         if (read_signal) r.rs_busy++;
         if (read_signal && write_signal) r.both++;
         if (mem_req && !prev_req) begin
            r.mreq_rises++;
            if (r.req_cyc < 0) begin
               r.req_cyc = cyc; r.maddr = mem_addr; r.mwe = mem_we; r.mwdata = mem_wdata;
               ack_at = cyc + k;
            end
         end
         prev_req = mem_req;
         if (cyc == ack_at) begin mem_ack = 1'b1; mem_rdata = mdata; end
         if (write_signal) begin r.ws_count++; r.idx = ram_index; r.tag = ram_tag; r.rwd = ram_wdata; end
         if (cpu_ready) begin
            r.ready_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++; $display("FAIL sb_unexpected_ready: cpu_ready with nothing expected");
            end else begin
               exp_v = exp_q.pop_front();
               if (cpu_rdata !== exp_v) begin n_fails++; $display("FAIL sb_rdata: got %h want %h", cpu_rdata, exp_v); end
            end
         end
      end
      @(negedge clk);
      cpu_req = 1'b0; mem_ack = 1'b0;
      #1 r.busy_after = cpu_busy;
      if (r.ready_cyc < 0) begin
         n_checks++; n_fails++;
         $display("FAIL txn_timeout: no cpu_ready within 40 cycles for addr %h", addr);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cpu_rdata, cpu_ready, cpu_busy, read_signal, write_signal, ram_index, ram_tag, ram_wdata} !== '0) begin
         n_fails++; $display("FAIL reset_cpu_ram: got %h want 0", {cpu_rdata, cpu_ready, cpu_busy, read_signal, write_signal, ram_index, ram_tag, ram_wdata});
      end
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count} !== '0) begin
         n_fails++; $display("FAIL reset_mem_cnt: got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_miss();
      res_t r;
      txn(1'b0, 5'b01011, 8'h00, 1'b0, 2'b00, 8'h00, 3, 8'hA5, 1'b0, r);
      n_checks++; if (r.rs0 !== 1'b1) begin n_fails++; $display("FAIL rm_read_signal: got %b want 1", r.rs0); end
      n_checks++; if (r.req_cyc != 2) begin n_fails++; $display("FAIL rm_req_cycle: got %0d want 2", r.req_cyc); end
      n_checks++; if (r.maddr !== 5'h0B || r.mwe !== 1'b0) begin n_fails++; $display("FAIL rm_mem_addr: got %h/%b want 0b/0", r.maddr, r.mwe); end
      n_checks++; if (r.ws_count != 1 || r.idx !== 3'd3 || r.tag !== 2'b01 || r.rwd !== 8'hA5) begin
         n_fails++; $display("FAIL rm_fill: got n=%0d idx=%0d tag=%b data=%h want 1/3/01/a5", r.ws_count, r.idx, r.tag, r.rwd); end
      n_checks++; if (r.ready_cyc != 7) begin n_fails++; $display("FAIL rm_latency: got %0d want 7", r.ready_cyc); end
      n_checks++; if (miss_count !== 8'd1 || hit_count !== 8'd0) begin n_fails++; $display("FAIL rm_counts: got h=%0d m=%0d want 0/1", hit_count, miss_count); end
      n_checks++; if (r.busy_after !== 1'b0) begin n_fails++; $display("FAIL rm_busy_fall: got %b want 0", r.busy_after); end
   endtask

   task automatic test_read_hit();
      res_t r;
      txn(1'b0, 5'b01011, 8'h00, 1'b1, 2'b01, 8'hA5, 0, 8'h00, 1'b0, r);
      n_checks++; if (r.ready_cyc != 2) begin n_fails++; $display("FAIL rh_latency: got %0d want 2", r.ready_cyc); end
      n_checks++; if (r.mreq_rises != 0 || r.ws_count != 0) begin n_fails++; $display("FAIL rh_no_mem: got req=%0d ws=%0d want 0/0", r.mreq_rises, r.ws_count); end
      n_checks++; if (hit_count !== 8'd1) begin n_fails++; $display("FAIL rh_hit_count: got %0d want 1", hit_count); end
   endtask

   task automatic test_tag_mismatch();
      res_t r;
      txn(1'b0, 5'b11011, 8'h00, 1'b1, 2'b01, 8'hA5, 1, 8'h5A, 1'b0, r);
      n_checks++; if (r.req_cyc != 2 || r.maddr !== 5'h1B) begin n_fails++; $display("FAIL tm_mem_req: got cyc=%0d addr=%h want 2/1b", r.req_cyc, r.maddr); end
      n_checks++; if (r.ws_count != 1 || r.tag !== 2'b11 || r.rwd !== 8'h5A) begin
         n_fails++; $display("FAIL tm_fill: got n=%0d tag=%b data=%h want 1/11/5a", r.ws_count, r.tag, r.rwd); end
      n_checks++; if (r.ready_cyc != 5) begin n_fails++; $display("FAIL tm_latency: got %0d want 5", r.ready_cyc); end
      n_checks++; if (miss_count !== 8'(exp_miss)) begin n_fails++; $display("FAIL tm_miss_count: got %0d want %0d", miss_count, exp_miss); end
   endtask

   task automatic test_write();
      res_t r;
      txn(1'b1, 5'b11011, 8'h3C, 1'b1, 2'b11, 8'h5A, 2, 8'h00, 1'b0, r);
      n_checks++; if (r.mwe !== 1'b1 || r.mwdata !== 8'h3C || r.maddr !== 5'h1B) begin
         n_fails++; $display("FAIL wh_mem: got we=%b data=%h addr=%h want 1/3c/1b", r.mwe, r.mwdata, r.maddr); end
      n_checks++; if (r.ws_count != 1 || r.rwd !== 8'h3C || r.idx !== 3'd3 || r.tag !== 2'b11) begin
         n_fails++; $display("FAIL wh_fill: got n=%0d data=%h idx=%0d tag=%b want 1/3c/3/11", r.ws_count, r.rwd, r.idx, r.tag); end
      n_checks++; if (r.ready_cyc != 6) begin n_fails++; $display("FAIL wh_latency: got %0d want 6", r.ready_cyc); end
      n_checks++; if (hit_count !== 8'(exp_hit)) begin n_fails++; $display("FAIL wh_hit_count: got %0d want %0d", hit_count, exp_hit); end
      txn(1'b1, 5'b00100, 8'h3C, 1'b0, 2'b00, 8'h00, 0, 8'h00, 1'b0, r);
      n_checks++; if (r.mwe !== 1'b1 || r.mwdata !== 8'h3C) begin n_fails++; $display("FAIL wm_mem: got we=%b data=%h want 1/3c", r.mwe, r.mwdata); end
      n_checks++; if (r.ws_count != 0) begin n_fails++; $display("FAIL wm_no_fill: got %0d want 0", r.ws_count); end
      n_checks++; if (r.ready_cyc != 3) begin n_fails++; $display("FAIL wm_latency: got %0d want 3", r.ready_cyc); end
      n_checks++; if (miss_count !== 8'(exp_miss) || hit_count !== 8'(exp_hit)) begin
         n_fails++; $display("FAIL wm_counts: got h=%0d m=%0d want %0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
   endtask

   task automatic test_back_to_back();
      res_t r;
      txn(1'b0, 5'b00001, 8'h00, 1'b0, 2'b00, 8'h00, 4, 8'h77, 1'b1, r);
      n_checks++; if (r.mreq_rises != 1) begin n_fails++; $display("FAIL bb_single_req: got %0d want 1", r.mreq_rises); end
      n_checks++; if (r.rs_busy != 0 || r.both != 0) begin n_fails++; $display("FAIL bb_read_signal: got rs=%0d both=%0d want 0/0", r.rs_busy, r.both); end
      n_checks++; if (r.ready_cyc != 8) begin n_fails++; $display("FAIL bb_latency: got %0d want 8", r.ready_cyc); end
      txn(1'b0, 5'b00001, 8'h00, 1'b1, 2'b00, 8'h77, 0, 8'h00, 1'b0, r);
      n_checks++; if (r.ready_cyc != 2 || r.mreq_rises != 0) begin n_fails++; $display("FAIL bb_next_hit: got cyc=%0d req=%0d want 2/0", r.ready_cyc, r.mreq_rises); end
   endtask

   task automatic test_reset_in_mem();
      int n_ready, n_ws, n_req;
      n_ready = 0; n_ws = 0; n_req = 0;
      @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'b10110;
      @(negedge clk); cpu_req = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b1) begin n_fails++; $display("FAIL rst_pre_req: got %b want 1", mem_req); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (mem_req !== 1'b0 || cpu_busy !== 1'b0) begin n_fails++; $display("FAIL rst_drop: got req=%b busy=%b want 0/0", mem_req, cpu_busy); end
      n_checks++; if (hit_count !== 8'd0 || miss_count !== 8'd0 || cpu_rdata !== 8'h00) begin
         n_fails++; $display("FAIL rst_state: got h=%0d m=%0d rd=%h want 0/0/00", hit_count, miss_count, cpu_rdata); end
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      repeat (6) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (cpu_ready) n_ready++;
         if (write_signal) n_ws++;
         if (mem_req || cpu_busy) n_req++;
      end
      n_checks++; if (n_ready != 0 || n_ws != 0 || n_req != 0) begin
         n_fails++; $display("FAIL rst_late_ack: got ready=%0d ws=%0d active=%0d want 0/0/0", n_ready, n_ws, n_req); end
      last_rdata = 8'h00; exp_hit = 0; exp_miss = 0;
   endtask

   task automatic test_saturation();
      res_t r;
      for (int i = 0; i < 300; i++) begin
         txn(1'b0, 5'b00001, 8'h00, 1'b1, 2'b00, 8'h77, 0, 8'h00, 1'b0, r);
         if (i == 254) begin
            n_checks++; if (hit_count !== 8'd255) begin n_fails++; $display("FAIL sat_reach: got %0d want 255", hit_count); end
         end
      end
      n_checks++; if (hit_count !== 8'd255 || hit_count !== 8'(exp_hit)) begin n_fails++; $display("FAIL sat_hold: got %0d want 255", hit_count); end
      n_checks++; if (miss_count !== 8'd0) begin n_fails++; $display("FAIL sat_miss: got %0d want 0", miss_count); end
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      valid_in = 1'b0; tag_in = '0; line_in = '0; mem_rdata = '0; mem_ack = 1'b0;
      n_checks = 0; n_fails = 0; last_rdata = 8'h00; exp_hit = 0; exp_miss = 0;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_tag_mismatch();
      test_write();
      test_back_to_back();
      test_reset_in_mem();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Request controller for the direct-mapped cache; sits directly upstream of the valid-bit RAM and the tag/data RAMs. It accepts CPU read/write requests and drives the RAM lookup (read_signal). It compares the returned tag, runs the miss path to main memory over a req/ack handshake, and fills the line (write_signal). Write policy: write-through, no write-allocate; reads allocate on miss.

Parameters:
index, 3, cache index width
cachesize, 8, number of lines (2**index)
memory_bits, 5, CPU/memory address width; tag width T = memory_bits-index
data_bits, 8, data word width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
cpu_req  in  1  request strobe, accepted only when cpu_busy=0
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  memory_bits  request address
cpu_wdata  in  data_bits  write data
cpu_rdata  out  data_bits  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_busy  out  1  high from accept until the cycle after cpu_ready
read_signal  out  1  lookup strobe to valid/tag/data RAMs
write_signal  out  1  line-write strobe to valid/tag/data RAMs
ram_index  out  index  line index = latched addr[index-1:0]
ram_tag  out  T  tag to write = latched addr[memory_bits-1:index]
ram_wdata  out  data_bits  line data to write
valid_in  in  1  valid bit from valid RAM; registered, 1 cycle after read_signal
tag_in  in  T  stored tag, same timing as valid_in
line_in  in  data_bits  stored data, same timing as valid_in
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write qualifier
mem_addr  out  memory_bits  memory address
mem_wdata  out  data_bits  memory write data
mem_rdata  in  data_bits  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle memory acknowledge
hit_count  out  8  saturating read+write hit counter
miss_count  out  8  saturating read+write miss counter

Behaviour:
- Reset values: all outputs 0; state IDLE; latched address/data 0; counters 0.
- Reset has priority in any state. It drops mem_req the same edge and abandons the transfer; a later mem_ack is ignored.
- States: IDLE, LOOKUP, MEM, FILL, RESP.
- IDLE:
  - cpu_req=1 latches cpu_we, cpu_addr and cpu_wdata.
  - read_signal=1 in that cycle, driven combinationally from cpu_req while in IDLE.
  - Next state: LOOKUP. cpu_busy rises next cycle.
- LOOKUP: hit = valid_in & (tag_in == latched tag).
  - Read hit: cpu_rdata <= line_in; hit_count++; go to RESP.
  - Read miss: miss_count++; mem_req=1, mem_we=0, mem_addr=latched addr; go to MEM.
  - Write: mem_req=1, mem_we=1, mem_wdata=latched wdata; go to MEM.
  - Write hit/miss is recorded in a flag and counted here.
- MEM:
  - Hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack=1; there is no timeout.
  - On mem_ack, mem_req drops next edge.
  - Read miss: capture mem_rdata, go to FILL.
  - Write hit: go to FILL.
  - Write miss: go to RESP, with no cache update.
- FILL: write_signal=1 for exactly one cycle, with ram_index/ram_tag from the latched addr.
  - ram_wdata = fetched data (read) or latched wdata (write hit).
  - cpu_rdata <= fetched data on read.
  - Go to RESP.
- RESP: cpu_ready=1 for one cycle; go to IDLE. cpu_busy falls the following cycle.
- read_signal and write_signal are never high together.
- cpu_req while busy is ignored, not queued. mem_ack outside MEM is ignored.
- Latency, accept cycle = 0:
  - Read hit: cpu_ready at cycle 2.
  - Read miss with mem_ack at cycle 2+k: FILL at 3+k, cpu_ready at 4+k.
  - Write miss: cpu_ready at 3+k.
- Counters saturate at 255; no wrap.
- cpu_rdata holds its last value outside cpu_ready.

Test Plan:
- Reset, then read addr 5'b01011 with valid_in=0 and mem_ack 3 cycles after mem_req (mem_rdata=8'hA5). Required: mem_addr=5'h0B; write_signal pulse with ram_index=3, ram_tag=2'b01, ram_wdata=A5; cpu_rdata=A5; miss_count=1.
- Read same addr with valid_in=1, tag_in=2'b01, line_in=8'hA5. Required: cpu_ready at cycle 2, cpu_rdata=A5, hit_count=1, mem_req stays 0.
- Read addr 5'b11011 with valid_in=1, tag_in=2'b01. Required: tag mismatch is a miss; mem_req asserted; after fill, ram_tag=2'b11.
- Write 8'h3C to a hit line, then to a miss line. Required for both: mem_we=1, mem_wdata=3C. Hit: write_signal pulses once. Miss: write_signal stays 0. Counters +1 hit, +1 miss.
- Assert reset while in MEM before mem_ack, then send mem_ack. Required: mem_req=0 next edge; state IDLE; counters 0; no cpu_ready; no write_signal.
- Pulse cpu_req during a busy miss, and issue 300 hits. Required: extra request ignored with no second mem_req; hit_count saturates at 255.
